fxdiv_ctrl: RTL

Sequencing controller sitting directly upstream of the fixed-point divider datapath. It:
- accepts an operand pair over a valid/ready handshake;
- drives the datapath's load, init and start strobes;
- watches the datapath's iteration carry-out, divide-by-zero and overflow flags;
- returns the 10-bit quotient plus error status over a second valid/ready handshake.

It also owns datapath re-initialisation between operations and a watchdog against a stalled iteration counter.

---
 rtl/fxdiv_ctrl_if.sv | 28 ++
 rtl/fxdiv_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fxdiv_ctrl_if.sv
// Operand/result handshake bundle for the fixed-point divider controller.
//   master : producer of operands and consumer of results (drives in_valid,
//            a_in, b_in, out_ready)
//   slave  : the controller (drives in_ready, out_valid, q_out, err_*)
interface fxdiv_ctrl_if #(
   parameter int unsigned W = 10
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q_out;
   logic         err_dvz;
   logic         err_ov;
   logic         err_tmo;

   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, q_out, err_dvz, err_ov, err_tmo
   );

   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, q_out, err_dvz, err_ov, err_tmo
   );
endinterface

// File: rtl/fxdiv_ctrl.sv
// Sequencing controller for the fixed-point divider datapath.
// Accepts an operand pair, loads/initialises/iterates the datapath, watches
// its carry-out, divide-by-zero and overflow flags, and returns the quotient
// with error status. Includes a watchdog against a stalled iteration counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       in_valid/in_ready/a_in/b_in operand channel,
//                     out_valid/out_ready/q_out/err_dvz/err_ov/err_tmo result channel
//   busy              high in any state but IDLE
//   dp_rst            datapath counter/ACC/Q reset
//   dp_ld_a, dp_ld_b  datapath operand register loads
//   dp_A, dp_B        operands to the datapath (from holding registers)
//   dp_loading_done   datapath ACC/Q initialise strobe
//   dp_start          datapath iterate enable
//   dp_q, dp_ov, dp_dvz, dp_co  datapath quotient and status flags
module fxdiv_ctrl #(
   parameter int unsigned W          = 10,
   parameter int unsigned TMO_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   fxdiv_ctrl_if.slave  bus,
   output logic         busy,
   output logic         dp_rst,
   output logic         dp_ld_a,
   output logic         dp_ld_b,
   output logic [W-1:0] dp_A,
   output logic [W-1:0] dp_B,
   output logic         dp_loading_done,
   output logic         dp_start,
   input  logic [W-1:0] dp_q,
   input  logic         dp_ov,
   input  logic         dp_dvz,
   input  logic         dp_co
);

   localparam int unsigned WD_W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   logic            in_ready_r;
   logic            busy_r;
   logic            out_valid_r;
   logic [W-1:0]    q_r;
   logic            err_dvz_r;
   logic            err_ov_r;
   logic            err_tmo_r;
   logic [W-1:0]    a_hold;
   logic [W-1:0]    b_hold;
   logic            dp_rst_r;
   logic            dp_ld_r;
   logic            dp_start_r;
   logic            ov_sticky;
   logic [WD_W-1:0] wd_cnt;

   // Controller FSM; every output register is set for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         q_r         <= '0;
         err_dvz_r   <= 1'b0;
         err_ov_r    <= 1'b0;
         err_tmo_r   <= 1'b0;
         a_hold      <= '0;
         b_hold      <= '0;
         dp_rst_r    <= 1'b0;
         dp_ld_r     <= 1'b0;
         dp_start_r  <= 1'b0;
         ov_sticky   <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_hold     <= bus.a_in;
                  b_hold     <= bus.b_in;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  dp_ld_r    <= 1'b1;
                  dp_rst_r   <= 1'b1;
                  state      <= S_LOAD;
               end
            end

            S_LOAD: begin
               dp_ld_r  <= 1'b0;
               dp_rst_r <= 1'b0;
               state    <= S_CHECK;
            end

            // dp_dvz now reflects the freshly loaded divisor.
            S_CHECK: begin
               if (dp_dvz) begin
                  q_r         <= '1;
                  err_dvz_r   <= 1'b1;
                  out_valid_r <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wd_cnt     <= '0;
                  ov_sticky  <= 1'b0;
                  dp_start_r <= 1'b1;
                  state      <= S_RUN;
               end
            end

            // Carry-out wins over the watchdog when both land on the same cycle.
            S_RUN: begin
               ov_sticky <= ov_sticky | dp_ov;
               wd_cnt    <= wd_cnt + WD_W'(1);
               if (dp_co) begin
                  q_r         <= dp_q;
                  err_ov_r    <= ov_sticky | dp_ov;
                  out_valid_r <= 1'b1;
                  dp_start_r  <= 1'b0;
                  state       <= S_DONE;
               end else if (wd_cnt == WD_LAST) begin
                  q_r         <= '0;
                  err_tmo_r   <= 1'b1;
                  out_valid_r <= 1'b1;
                  dp_start_r  <= 1'b0;
                  state       <= S_DONE;
               end
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  err_dvz_r   <= 1'b0;
                  err_ov_r    <= 1'b0;
                  err_tmo_r   <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // Holds in_ready low while reset is applied, yet high the cycle it releases.
   assign bus.in_ready  = in_ready_r & ~rst;
   assign bus.out_valid = out_valid_r;
   assign bus.q_out     = q_r;
   assign bus.err_dvz   = err_dvz_r;
   assign bus.err_ov    = err_ov_r;
   assign bus.err_tmo   = err_tmo_r;

   assign busy     = busy_r;
   assign dp_rst   = dp_rst_r;
   assign dp_ld_a  = dp_ld_r;
   assign dp_ld_b  = dp_ld_r;
   assign dp_A     = a_hold;
   assign dp_B     = b_hold;
   assign dp_start = dp_start_r;

   // Initialise strobe must sit in CHECK itself (ahead of the first iterate
   // cycle) and be suppressed by the same-cycle divisor-zero flag.
   assign dp_loading_done = (state == S_CHECK) & ~dp_dvz;

endmodule
